// File: rtl/auc_wnaf_enc_pkg.sv
// auc_wnaf_enc_pkg: shared constants, FSM state codes and buffer-entry layout for the wNAF recoder
package auc_wnaf_enc_pkg;

   localparam int WNAF_WIDTH   = 256;
   localparam int WNAF_WINDOW  = 4;
   localparam int WNAF_SWINDOW = WNAF_WINDOW - 2;
   localparam int WNAF_DADDR   = 9;

   // buffer entry = {nz, sign, idx[SWINDOW-1:0]}; |d| = 2*idx+1 when nz
   localparam int WNAF_EW = WNAF_SWINDOW + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ENC  = 2'd1,
      ST_OUT  = 2'd2
   } wnaf_state_t;

endpackage

// File: rtl/auc_wnaf_enc_buf.sv
// auc_wnaf_buf: digit register file, one synchronous write port and one combinational read port
module auc_wnaf_buf
   import auc_wnaf_enc_pkg::*;
#(
   parameter int DEPTH = WNAF_WIDTH + 1,
   parameter int AW    = WNAF_DADDR,
   parameter int DW    = WNAF_EW
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // contents need no reset: every presented entry is written before it is read
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/auc_wnaf_enc.sv
// auc_wnaf_enc: width-w NAF recoder, encodes LSB-first into a buffer and presents digits MSB-first
module auc_wnaf_enc
   import auc_wnaf_enc_pkg::*;
#(
   parameter int WIDTH   = WNAF_WIDTH,
   parameter int WINDOW  = WNAF_WINDOW,
   parameter int SWINDOW = WINDOW - 2,
   parameter int SH_WID  = (1 << SWINDOW) + 1,
   parameter int DADDR   = WNAF_DADDR
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wnaf_en,
   input  logic [WIDTH-1:0]  wnaf_k,
   output logic              wnaf_busy,
   output logic [SH_WID-1:0] wnaf_naf_vlue,
   output logic              wnaf_naf_rdy,
   output logic              wnaf_naf_last,
   input  logic              wnaf_shft_en
);

   localparam int KW = WIDTH + 1;
   localparam int EW = SWINDOW + 2;

   wnaf_state_t        r_state, w_state_nxt;
   logic [KW-1:0]      r_kr, w_kr_nxt;
   logic [DADDR-1:0]   r_ptr, w_ptr_nxt;
   logic [DADDR-1:0]   r_rp, w_rp_nxt;

   logic               w_neg;
   logic [SWINDOW-1:0] w_idx;
   logic [KW-1:0]      w_mag, w_kr_sub, w_kr_enc;
   logic [EW-1:0]      w_ent, w_wdata, w_rd_ent;
   logic               w_we;
   logic [DADDR-1:0]   w_waddr;
   logic [SH_WID-2:0]  w_oh;

   // digit arithmetic: a window residue with its top bit set becomes a negative digit,
   // whose magnitude index is the complemented middle bits of the residue
   always_comb begin
      w_neg    = r_kr[WINDOW-1];
      w_idx    = w_neg ? ~r_kr[SWINDOW:1] : r_kr[SWINDOW:1];
      w_mag    = {{(KW-SWINDOW-1){1'b0}}, w_idx, 1'b1};
      w_kr_sub = !r_kr[0] ? r_kr : w_neg ? r_kr + w_mag : r_kr - w_mag;
      w_kr_enc = w_kr_sub >> 1;
      w_ent    = r_kr[0] ? {1'b1, w_neg, w_idx} : '0;
   end

   // next-state and datapath control for IDLE/ENC/OUT
   always_comb begin
      w_state_nxt = r_state;
      w_kr_nxt    = r_kr;
      w_ptr_nxt   = r_ptr;
      w_rp_nxt    = r_rp;
      w_we        = 1'b0;
      w_waddr     = r_ptr;
      w_wdata     = w_ent;
      case (r_state)
         ST_IDLE: begin
            if (wnaf_en) begin
               w_kr_nxt  = {1'b0, wnaf_k};
               w_ptr_nxt = '0;
               if (wnaf_k == '0) begin
                  w_we        = 1'b1;
                  w_waddr     = '0;
                  w_wdata     = '0;
                  w_rp_nxt    = '0;
                  w_state_nxt = ST_OUT;
               end else begin
                  w_state_nxt = ST_ENC;
               end
            end
         end
         ST_ENC: begin
            w_we      = 1'b1;
            w_kr_nxt  = w_kr_enc;
            w_ptr_nxt = r_ptr + DADDR'(1);
            if (w_kr_enc == '0) begin
               w_rp_nxt    = r_ptr;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (wnaf_shft_en) begin
               if (r_rp == '0) w_state_nxt = ST_IDLE;
               else            w_rp_nxt    = r_rp - DADDR'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // state and pointer registers; reset abandons any operation in progress
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_kr    <= '0;
         r_ptr   <= '0;
         r_rp    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_kr    <= w_kr_nxt;
         r_ptr   <= w_ptr_nxt;
         r_rp    <= w_rp_nxt;
      end
   end

   auc_wnaf_buf #(
      .DEPTH (KW),
      .AW    (DADDR),
      .DW    (EW)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_rp),
      .o_rdata (w_rd_ent)
   );

   // outputs decode registered state only; the read pointer is a register
   assign w_oh          = (SH_WID-1)'(w_rd_ent[EW-1]) << w_rd_ent[SWINDOW-1:0];
   assign wnaf_busy     = r_state != ST_IDLE;
   assign wnaf_naf_rdy  = r_state == ST_OUT;
   assign wnaf_naf_last = r_state == ST_OUT && r_rp == '0;
   assign wnaf_naf_vlue = r_state == ST_OUT ? {w_rd_ent[EW-1] & w_rd_ent[SWINDOW], w_oh} : '0;

endmodule

// File: tb/tb_auc_wnaf_enc.sv
// tb_auc_wnaf_enc: scoreboard bench for the wNAF recoder, directed digit sequences plus sum/spacing properties
module tb_auc_wnaf_enc;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wnaf_en = 1'b0;
   logic [255:0] wnaf_k = '0;
   logic         wnaf_busy;
   logic [4:0]   wnaf_naf_vlue;
   logic         wnaf_naf_rdy;
   logic         wnaf_naf_last;
   logic         wnaf_shft_en = 1'b0;

   typedef struct packed {
      logic         prop;
      logic [4:0]   val;
      logic         last;
      logic [255:0] k;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   mode   = 0;
   logic chk_idle = 1'b0;

   auc_wnaf_enc dut (
      .clk           (clk),
      .rst           (rst),
      .wnaf_en       (wnaf_en),
      .wnaf_k        (wnaf_k),
      .wnaf_busy     (wnaf_busy),
      .wnaf_naf_vlue (wnaf_naf_vlue),
      .wnaf_naf_rdy  (wnaf_naf_rdy),
      .wnaf_naf_last (wnaf_naf_last),
      .wnaf_shft_en  (wnaf_shft_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_d(input logic [4:0] v, input logic l);
      q.push_back('{prop: 1'b0, val: v, last: l, k: '0});
   endtask

   task automatic start(input logic [255:0] k, input int lat);
      int c;
      wnaf_k  = k;
      wnaf_en = 1'b1;
      @(posedge clk); #1;
      wnaf_en = 1'b0;
      wnaf_k  = '0;
      c = 1;
      while (!wnaf_naf_rdy && c < 400) begin
         @(posedge clk); #1;
         c++;
      end
      if (lat > 0) chk("latency", c, lat);
   endtask

   task automatic drain;
      int c = 0;
      while (wnaf_busy && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      chk("drain", wnaf_busy, 0);
   endtask

   // consumer: shift never (0), every cycle (1) or randomly (2)
   initial begin
      forever begin
         @(posedge clk); #1;
         wnaf_shft_en = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      end
   end

   // monitor: checks each digit on the cycle it is consumed
   initial begin
      logic signed [263:0] acc;
      int zeros, mag;
      bit first;
      exp_t e;
      acc = '0; zeros = 0; first = 1;
      forever begin
         @(negedge clk);
         if (chk_idle) begin
            chk_idle = 1'b0;
            chk("idle_after_last", {wnaf_busy, wnaf_naf_rdy, wnaf_naf_last}, 0);
         end
         if (rst && wnaf_naf_rdy && wnaf_shft_en) begin
            if (q.size() == 0) begin
               chk("unexpected_digit", {wnaf_naf_vlue, wnaf_naf_last}, 6'h3f);
            end else if (!q[0].prop) begin
               e = q.pop_front();
               chk("digit", wnaf_naf_vlue, e.val);
               chk("last", wnaf_naf_last, e.last);
               if (wnaf_naf_last) chk_idle = 1'b1;
            end else begin
               mag = 0;
               for (int j = 0; j < 4; j++) if (wnaf_naf_vlue[j]) mag = 2 * j + 1;
               if (wnaf_naf_vlue[3:0] != 0) chk("onehot", $countones(wnaf_naf_vlue[3:0]), 1);
               if (first) chk("msd_nonzero", mag != 0, 1);
               if (mag != 0) begin
                  if (!first) chk("spacing", zeros >= 3, 1);
                  zeros = 0;
               end else zeros++;
               first = 0;
               acc = acc * 2 + (wnaf_naf_vlue[4] ? -mag : mag);
               if (wnaf_naf_last) begin
                  e = q.pop_front();
                  chk("sum", acc[259:0], {4'b0, e.k});
                  acc = '0; zeros = 0; first = 1;
                  chk_idle = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] k;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {wnaf_busy, wnaf_naf_rdy, wnaf_naf_last, wnaf_naf_vlue}, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      mode = 1;
      exp_d(5'b00001, 0); exp_d(0, 0); exp_d(0, 0); exp_d(0, 0); exp_d(5'b10100, 1);
      start(256'd11, 6); drain();

      exp_d(5'b01000, 1);
      start(256'd7, 2); drain();

      exp_d(5'b00000, 1);
      start(256'd0, 1); drain();

      mode = 2;
      exp_d(5'b00001, 0); exp_d(0, 0); exp_d(0, 0); exp_d(0, 0); exp_d(5'b11000, 1);
      start(256'd9, 6); drain();

      exp_d(5'b00001, 0); exp_d(0, 0); exp_d(0, 0); exp_d(0, 0); exp_d(5'b00100, 1);
      start(256'd21, 6); drain();

      exp_d(5'b00010, 0); exp_d(5'b00000, 1);
      start(256'd6, 3); drain();

      mode = 1;
      exp_d(5'b00001, 0);
      for (int i = 0; i < 255; i++) exp_d(0, 0);
      exp_d(5'b10001, 1);
      start({256{1'b1}}, 258); drain();

      // random scalars with the consumer stalling and stray start pulses while busy
      mode = 2;
      for (int t = 0; t < 3; t++) begin
         for (int j = 0; j < 8; j++) k[j*32 +: 32] = $urandom;
         q.push_back('{prop: 1'b1, val: 5'd0, last: 1'b0, k: k});
         wnaf_k  = k;
         wnaf_en = 1'b1;
         @(posedge clk); #1;
         wnaf_k = 256'd5;
         repeat (2) @(posedge clk);
         #1;
         wnaf_en = 1'b0;
         for (int c = 0; c < 400 && !wnaf_naf_rdy; c++) begin
            @(posedge clk); #1;
         end
         wnaf_k  = 256'd3;
         wnaf_en = 1'b1;
         @(posedge clk); #1;
         wnaf_en = 1'b0;
         drain();
      end

      // reset in the middle of OUT aborts the operation
      mode = 0;
      start(256'd11, 6);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_outputs", {wnaf_busy, wnaf_naf_rdy, wnaf_naf_last, wnaf_naf_vlue}, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_idle", {wnaf_busy, wnaf_naf_rdy}, 0);
      mode = 1;
      exp_d(5'b00010, 1);
      start(256'd3, 2); drain();

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
